// File: rtl/shift_norm_if.sv
// Start/valid handshake between a requester and the sequential normalizer.
// The master drives the operand; the slave returns the normalized word and the shift count.
interface shift_norm_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] operand;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cnt;
    logic             zero;
    logic             sat;

    modport master (
        output start, mode, operand,
        input  busy, valid, result, cnt, zero, sat
    );

    modport slave (
        input  start, mode, operand,
        output busy, valid, result, cnt, zero, sat
    );
endinterface

// File: rtl/shift_norm_seq.sv
// Sequential normalizer: shifts the operand left one bit per cycle until it is normalized,
// then reports the normalized word and the number of shifts applied.
module shift_norm_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    shift_norm_if.slave  bus
);
    localparam logic [CNT_W-1:0] MaxCnt = '1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] word_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q;
    logic             zero_q;
    logic             sat_q;
    logic             busy_q;
    logic             valid_q;

    logic degenerate;
    logic normalized;

    // Signed mode treats both all-zeros and all-ones as having no significant bits.
    assign degenerate = bus.mode ? ((bus.operand == '0) || (bus.operand == '1))
                                 : (bus.operand == '0);
    assign normalized = mode_q ? (word_q[WIDTH-1] ^ word_q[WIDTH-2]) : word_q[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            word_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            zero_q  <= 1'b0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        word_q <= bus.operand;
                        mode_q <= bus.mode;
                        cnt_q  <= '0;
                        sat_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (degenerate) begin
                            zero_q  <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            zero_q  <= 1'b0;
                            state_q <= StShift;
                        end
                    end
                end
                StShift: begin
                    if (normalized) begin
                        valid_q <= 1'b1;
                        state_q <= StDone;
                    end else if (cnt_q == MaxCnt) begin
                        sat_q   <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        word_q <= {word_q[WIDTH-2:0], 1'b0};
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.valid  = valid_q;
    assign bus.result = word_q;
    assign bus.cnt    = cnt_q;
    assign bus.zero   = zero_q;
    assign bus.sat    = sat_q;
endmodule

// File: tb/tb_shift_norm_seq.sv
// Scoreboard bench for shift_norm_seq: expectations come from a leading-bit-count model
// and are queued at issue, then popped and compared when the DUT pulses valid.
module tb_shift_norm_seq;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] cnt;
        logic             zero;
        logic             sat;
        int               lat;
        int               acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t got;

    shift_norm_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shift_norm_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count leading copies of the top bit (mode 0: leading zeros; mode 1: redundant sign bits).
    function automatic exp_t model(input logic m, input logic [WIDTH-1:0] d);
        exp_t e;
        int   n;
        e.acc = 0;
        if ((d == '0) || (m && (d == '1))) begin
            e.data = d; e.cnt = '0; e.zero = 1'b1; e.sat = 1'b0; e.lat = 1;
            return e;
        end
        n = 0;
        if (!m) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (d[i]) break;
                n++;
            end
        end else begin
            for (int i = WIDTH - 2; i >= 0; i--) begin
                if (d[i] != d[WIDTH-1]) break;
                n++;
            end
        end
        e.zero = 1'b0;
        e.sat  = (n > 15);
        if (n > 15) n = 15;
        e.cnt  = CNT_W'(n);
        e.data = d << n;
        e.lat  = n + 2;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.valid) begin
            if (sb.size() == 0) begin
                check_eq("extra_valid", 64'd1, 64'd0);
            end else begin
                got = sb.pop_front();
                check_eq("data", 64'(bus.result), 64'(got.data));
                check_eq("cnt", 64'(bus.cnt), 64'(got.cnt));
                check_eq("zero", 64'(bus.zero), 64'(got.zero));
                check_eq("sat", 64'(bus.sat), 64'(got.sat));
                check_eq("latency", 64'(cyc - got.acc + 1), 64'(got.lat));
            end
        end
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 40 && bus.busy; i++) @(negedge clk);
        if (bus.busy) check_eq("busy_timeout", 64'd1, 64'd0);
    endtask

    // Issue one request at a negedge; optionally record the expected result.
    task automatic issue(input logic m, input logic [WIDTH-1:0] d, input bit expect_result);
        exp_t e;
        @(negedge clk);
        wait_idle();
        bus.start   = 1'b1;
        bus.mode    = m;
        bus.operand = d;
        if (expect_result) begin
            e = model(m, d);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start   = 1'b0;
        bus.mode    = 1'($urandom);
        bus.operand = $urandom;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) check_eq("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq(tag, {24'd0, bus.busy, bus.valid, bus.zero, bus.sat, bus.cnt, bus.result}, 64'd0);
    endtask

    initial begin
        int i;
        logic [WIDTH-1:0] d;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.mode    = 1'b0;
        bus.operand = '0;
        #1 check_outputs_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Normalized already, count-15 exact, saturation, signed cases
        issue(1'b0, 32'h8000_0000, 1'b1); wait_drain();
        repeat (3) @(negedge clk);
        check_eq("hold_result", 64'(bus.result), 64'h8000_0000);
        check_eq("hold_busy", 64'(bus.busy), 64'd0);
        issue(1'b0, 32'h0001_0000, 1'b1); wait_drain();
        issue(1'b0, 32'h0000_8000, 1'b1); wait_drain();
        issue(1'b1, 32'hF000_0000, 1'b1); wait_drain();
        issue(1'b1, 32'h0000_0100, 1'b1); wait_drain();
        issue(1'b0, 32'h0000_0000, 1'b1); wait_drain();
        issue(1'b1, 32'hFFFF_FFFF, 1'b1); wait_drain();
        issue(1'b1, 32'h0000_0000, 1'b1); wait_drain();
        issue(1'b1, 32'h4000_0000, 1'b1); wait_drain();
        issue(1'b0, 32'hFFFF_FFFF, 1'b1); wait_drain();

        // Back-to-back random traffic
        for (int k = 0; k < 16; k++) begin
            d = $urandom;
            d = d >> $urandom_range(0, 24);
            if ($urandom_range(0, 1) == 1) d = ~d;
            issue(1'($urandom), d, 1'b1);
        end
        wait_drain();

        // Starts during SHIFT and during DONE are dropped
        issue(1'b0, 32'h0000_0001, 1'b1);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.operand = 32'h8000_0000;
        @(negedge clk);
        bus.start = 1'b0;
        for (i = 0; i < 40 && !bus.valid; i++) @(negedge clk);
        check_eq("valid_seen", 64'(bus.valid), 64'd1);
        bus.start = 1'b1; bus.mode = 1'b1; bus.operand = 32'h0000_00F0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        check_eq("drop_done_start", 64'(bus.busy), 64'd0);
        check_eq("hold_sat", 64'(bus.sat), 64'd1);

        // Async reset mid-SHIFT aborts silently
        issue(1'b0, 32'h0000_0001, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("busy_before_reset", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_held");
        rst_n = 1'b1;
        issue(1'b1, 32'h0000_1234, 1'b1); wait_drain();
        issue(1'b0, 32'h0000_0003, 1'b1); wait_drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
